// File: rtl/mmio_peripheral.sv
// mmio_peripheral: memory-mapped responder for the 0x400000xx window on the data bus.
// It holds a 32-bit reload timer with an interrupt, an LED latch, a raw 7-segment latch,
// an auto-scanning 4-digit hex display and a free-running systick counter.
// Reads are combinational. Writes commit on the rising clock edge.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   addr      byte address; addr[31:8] selects the block, addr[7:2] selects the word
//   wdata     store data
//   mem_read  load strobe
//   mem_write store strobe
//   hit       addr falls inside this block's window
//   rdata     read data; zero unless mem_read && hit
//   leds      LED latch
//   bcd7      segment drive, active-low {dp,g,f,e,d,c,b,a}
//   an        digit enables, active-low
//   irq       timer interrupt status (TCON[2])
module mmio_peripheral #(
    parameter logic [23:0] BASE_HI  = 24'h400000,
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        hit,
    output logic [31:0] rdata,
    output logic [7:0]  leds,
    output logic [7:0]  bcd7,
    output logic [3:0]  an,
    output logic        irq
);

    // Word offsets within the window.
    localparam logic [5:0] OffTh      = 6'd0;
    localparam logic [5:0] OffTl      = 6'd1;
    localparam logic [5:0] OffTcon    = 6'd2;
    localparam logic [5:0] OffLed     = 6'd3;
    localparam logic [5:0] OffDigi    = 6'd4;
    localparam logic [5:0] OffSystick = 6'd5;
    localparam logic [5:0] OffHex     = 6'd6;
    localparam logic [5:0] OffDctl    = 6'd7;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;
    logic [15:0] hex_q, hex_d;
    logic        dctl_q, dctl_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  bcd7_q, bcd7_d;

    logic [5:0] off;
    logic       wr;
    logic       ovf;
    logic       unused_addr_lsb;

    assign hit             = (addr[31:8] == BASE_HI);
    assign off             = addr[7:2];
    assign wr              = mem_write && hit;
    assign unused_addr_lsb = ^addr[1:0];

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign ovf = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        hex_d     = hex_q;
        dctl_d    = dctl_q;
        systick_d = systick_q + 32'd1;

        // Hardware timer update; a software write below takes precedence.
        if (tcon_q[0]) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (ovf && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end

        if (wr) begin
            case (off)
                OffTh:   th_d   = wdata;
                OffTl:   tl_d   = wdata;
                // An overflow in the same cycle keeps the status set despite a clear.
                OffTcon: tcon_d = {wdata[2] | (ovf & tcon_q[1]), wdata[1:0]};
                OffLed:  led_d  = wdata[7:0];
                OffDigi: digi_d = wdata[11:0];
                OffHex:  hex_d  = wdata[15:0];
                OffDctl: dctl_d = wdata[0];
                default: ;
            endcase
        end
    end

    // Display scan and pin drive.
    always_comb begin
        scan_cnt_d = 16'd0;
        idx_d      = 2'd0;
        an_d       = digi_q[11:8];
        bcd7_d     = digi_q[7:0];
        if (dctl_q) begin
            if (scan_cnt_q == SCAN_DIV - 16'd1) begin
                scan_cnt_d = 16'd0;
                idx_d      = idx_q + 2'd1;
            end else begin
                scan_cnt_d = scan_cnt_q + 16'd1;
                idx_d      = idx_q;
            end
            an_d   = ~(4'b0001 << idx_q);
            bcd7_d = {1'b1, seg7(hex_q[{idx_q, 2'b00} +: 4])};
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (mem_read && hit) begin
            case (off)
                OffTh:      rdata = th_q;
                OffTl:      rdata = tl_q;
                OffTcon:    rdata = {29'd0, tcon_q};
                OffLed:     rdata = {24'd0, led_q};
                OffDigi:    rdata = {20'd0, digi_q};
                OffSystick: rdata = systick_q;
                OffHex:     rdata = {16'd0, hex_q};
                OffDctl:    rdata = {31'd0, dctl_q};
                default:    rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q       <= 32'd0;
            tl_q       <= 32'd0;
            tcon_q     <= 3'd0;
            led_q      <= 8'd0;
            digi_q     <= 12'hFFF;
            systick_q  <= 32'd0;
            hex_q      <= 16'd0;
            dctl_q     <= 1'b0;
            scan_cnt_q <= 16'd0;
            idx_q      <= 2'd0;
            an_q       <= 4'hF;
            bcd7_q     <= 8'hFF;
        end else begin
            th_q       <= th_d;
            tl_q       <= tl_d;
            tcon_q     <= tcon_d;
            led_q      <= led_d;
            digi_q     <= digi_d;
            systick_q  <= systick_d;
            hex_q      <= hex_d;
            dctl_q     <= dctl_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            bcd7_q     <= bcd7_d;
        end
    end

    assign leds = led_q;
    assign an   = an_q;
    assign bcd7 = bcd7_q;
    assign irq  = tcon_q[2];

endmodule
